// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU issue controller, its register file and its
// request/completion interface.
//   DATA_W          : operand/result width
//   OP_*            : ALU select codes (0x0..0x9 legal, 0xA..0xF illegal)
//   N/Z/V/C_BIT     : bit positions inside a 4-bit NZVC flag vector
//   state_e         : issue FSM states
//   is_div_op()     : true for the two ops that fault on a zero divisor
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int DATA_W = 8;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_MUL = 4'h2;
   localparam logic [3:0] OP_DIV = 4'h3;
   localparam logic [3:0] OP_MOD = 4'h4;
   localparam logic [3:0] OP_CMP = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_OR  = 4'h7;
   localparam logic [3:0] OP_NOT = 4'h8;
   localparam logic [3:0] OP_XOR = 4'h9;

   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int V_BIT = 1;
   localparam int C_BIT = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage : alu_pkg

// File: rtl/alu_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_if
// Request and completion channels between instruction decode (master) and the
// ALU issue controller (slave).
//   req_valid/req_ready        : request handshake
//   req_op/rd/rs1/rs2          : ALU select and register indices
//   req_imm_en/req_imm         : immediate replaces rs2 as operand B
//   done_valid                 : one-cycle completion pulse
//   done_rd/data/nzvc          : completed destination, result and flags
//   err_div0/err_illegal       : error qualifiers, valid with done_valid
// -----------------------------------------------------------------------------
interface alu_issue_ctrl_if
   import alu_pkg::*;
#(
   parameter int REG_AW = 2
);

   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_op;
   logic [REG_AW-1:0] req_rd;
   logic [REG_AW-1:0] req_rs1;
   logic [REG_AW-1:0] req_rs2;
   logic              req_imm_en;
   logic [DATA_W-1:0] req_imm;

   logic              done_valid;
   logic [REG_AW-1:0] done_rd;
   logic [DATA_W-1:0] done_data;
   logic [3:0]        done_nzvc;
   logic              err_div0;
   logic              err_illegal;

   modport master (
      output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm_en, req_imm,
      input  req_ready,
      input  done_valid, done_rd, done_data, done_nzvc, err_div0, err_illegal
   );

   modport slave (
      input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm_en, req_imm,
      output req_ready,
      output done_valid, done_rd, done_data, done_nzvc, err_div0, err_illegal
   );

endinterface : alu_issue_ctrl_if

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// NUM_REGS x DATA_W architectural registers.
//   clk, rst                 : clock, asynchronous active-high reset (clears all)
//   we_i/waddr_i/wdata_i     : synchronous write port
//   raddr_a_i -> rdata_a_o   : combinational read, operand A
//   raddr_b_i -> rdata_b_o   : combinational read, operand B
//   raddr_dbg_i -> rdata_dbg_o : combinational read, debug
// -----------------------------------------------------------------------------
module alu_regfile
   import alu_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int REG_AW   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] raddr_a_i,
   output logic [DATA_W-1:0] rdata_a_o,
   input  logic [REG_AW-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_b_o,
   input  logic [REG_AW-1:0] raddr_dbg_i,
   output logic [DATA_W-1:0] rdata_dbg_o
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];

   // NOTE: the storage is reset because software relies on every register
   // reading 0 after reset; that rules out RAM inference, which is fine at
   // this depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o   = mem_q[raddr_a_i];
   assign rdata_b_o   = mem_q[raddr_b_i];
   assign rdata_dbg_o = mem_q[raddr_dbg_i];

endmodule : alu_regfile

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issues one operation at a time to an external combinational 8-bit ALU:
// accept (IDLE) -> drive ALU (EXEC) -> report (DONE), three cycles per op.
//   clk, rst                  : clock, asynchronous active-high reset
//   bus (slave)               : request handshake and completion channel
//   alu_a/alu_b/alu_sel       : registered operands and select to the ALU
//   alu_result/alu_nzvc       : ALU response, sampled at the end of EXEC
//   flags                     : architectural NZVC register
//   dbg_addr -> dbg_data      : combinational register file peek
// -----------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int REG_AW   = 2
) (
   input  logic              clk,
   input  logic              rst,
   alu_issue_ctrl_if.slave   bus,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_nzvc,
   output logic [3:0]        flags,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [3:0]        sel_q, sel_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [3:0]        flags_q, flags_d;
   logic [REG_AW-1:0] done_rd_q, done_rd_d;
   logic [DATA_W-1:0] done_data_q, done_data_d;
   logic [3:0]        done_nzvc_q, done_nzvc_d;
   logic              err_div0_q, err_div0_d;
   logic              err_illegal_q, err_illegal_d;

   logic              wr_en;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;

   alu_regfile #(
      .NUM_REGS (NUM_REGS),
      .REG_AW   (REG_AW)
   ) u_regfile (
      .clk         (clk),
      .rst         (rst),
      .we_i        (wr_en),
      .waddr_i     (rd_q),
      .wdata_i     (alu_result),
      .raddr_a_i   (bus.req_rs1),
      .rdata_a_o   (rs1_data),
      .raddr_b_i   (bus.req_rs2),
      .rdata_b_o   (rs2_data),
      .raddr_dbg_i (dbg_addr),
      .rdata_dbg_o (dbg_data)
   );

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      sel_d         = sel_q;
      rd_d          = rd_q;
      flags_d       = flags_q;
      done_rd_d     = '0;
      done_data_d   = '0;
      done_nzvc_d   = '0;
      err_div0_d    = 1'b0;
      err_illegal_d = 1'b0;
      wr_en         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               // Operands are captured here, so rd aliasing rs1/rs2 is harmless.
               state_d = EXEC;
               sel_d   = bus.req_op;
               rd_d    = bus.req_rd;
               a_d     = rs1_data;
               b_d     = bus.req_imm_en ? bus.req_imm : rs2_data;
            end
         end

         EXEC: begin
            state_d     = DONE;
            done_rd_d   = rd_q;
            done_data_d = alu_result;
            if (sel_q > OP_XOR) begin
               // Illegal select: ALU output is meaningless, nothing commits.
               err_illegal_d = 1'b1;
               done_data_d   = '0;
            end else if (is_div_op(sel_q) && (b_q == '0)) begin
               // Divisor checked on the latched operand, not on ALU flags.
               err_div0_d = 1'b1;
               flags_d    = 4'b1111;
            end else if (sel_q == OP_MOD) begin
               // The ALU leaves V and C undefined for modulo.
               wr_en   = 1'b1;
               flags_d = {alu_nzvc[N_BIT], alu_nzvc[Z_BIT], 2'b00};
            end else if (sel_q == OP_CMP) begin
               flags_d = alu_nzvc;
            end else begin
               wr_en   = 1'b1;
               flags_d = alu_nzvc;
            end
            done_nzvc_d = flags_d;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         sel_q         <= '0;
         rd_q          <= '0;
         flags_q       <= '0;
         done_rd_q     <= '0;
         done_data_q   <= '0;
         done_nzvc_q   <= '0;
         err_div0_q    <= 1'b0;
         err_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         sel_q         <= sel_d;
         rd_q          <= rd_d;
         flags_q       <= flags_d;
         done_rd_q     <= done_rd_d;
         done_data_q   <= done_data_d;
         done_nzvc_q   <= done_nzvc_d;
         err_div0_q    <= err_div0_d;
         err_illegal_q <= err_illegal_d;
      end
   end

   assign alu_a   = a_q;
   assign alu_b   = b_q;
   assign alu_sel = sel_q;
   assign flags   = flags_q;

   assign bus.req_ready   = (state_q == IDLE);
   assign bus.done_valid  = (state_q == DONE);
   assign bus.done_rd     = done_rd_q;
   assign bus.done_data   = done_data_q;
   assign bus.done_nzvc   = done_nzvc_q;
   assign bus.err_div0    = err_div0_q;
   assign bus.err_illegal = err_illegal_q;

endmodule : alu_issue_ctrl
